control_sequencer: RTL



---
 rtl/cu_pkg.sv | 65 ++++++
 rtl/cu_decode.sv | 80 ++++++++
 rtl/control_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the control sequencer
package cu_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    EXEC     = 2'b01,
    MEM_WAIT = 2'b10,
    HALT     = 2'b11
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_Z      = 3'd1;
  localparam logic [2:0] CC_NZ     = 3'd2;
  localparam logic [2:0] CC_GT     = 3'd3;
  localparam logic [2:0] CC_NN     = 3'd4;
  localparam logic [2:0] CC_N      = 3'd5;
  localparam logic [2:0] CC_LE     = 3'd6;
  localparam logic [2:0] CC_C      = 3'd7;

  localparam logic [1:0] MUXA_A    = 2'b00;
  localparam logic [1:0] MUXA_ZERO = 2'b01;

  localparam logic [1:0] MUXB_B    = 2'b00;
  localparam logic [1:0] MUXB_LIT  = 2'b01;
  localparam logic [1:0] MUXB_DM   = 2'b10;
  localparam logic [1:0] MUXB_ZERO = 2'b11;

  // Op 000 is used as a pass-through (A or zero) + (B or zero) for moves
  localparam logic [2:0] ALU_PASS  = 3'b000;

  typedef struct packed {
    logic       lrega;
    logic       lregb;
    logic [1:0] smuxa;
    logic [1:0] smuxb;
    logic [2:0] salu;
    logic       wdm;
    logic       smuxd;
    logic       lstatus;
  } ctrl_t;

  // flags = {Z, N, C, V}
  function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] flags);
    logic z, n, c;
    z = flags[3];
    n = flags[2];
    c = flags[1];
    case (cc)
      CC_ALWAYS: cond_met = 1'b1;
      CC_Z:      cond_met = z;
      CC_NZ:     cond_met = !z;
      CC_GT:     cond_met = !z && !n;
      CC_NN:     cond_met = !n;
      CC_N:      cond_met = n;
      CC_LE:     cond_met = n || z;
      default:   cond_met = c;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational decode of state + instruction register into controls
import cu_pkg::*;

module cu_decode #(
  parameter int OPW = 7
) (
  input  state_t           state,
  input  logic [OPW-1:0]   ir,
  input  logic [3:0]       flags,
  input  logic             mem_ready,
  output ctrl_t            ctrl,
  output logic             jump,
  output logic             is_mem,
  output logic             is_halt
);

  logic valid;
  logic unused_v;

  assign unused_v = flags[0];

  // Any set opcode bit above [6] turns the instruction into a NOP
  generate
    if (OPW > 7) begin : g_wide
      assign valid = (ir[OPW-1:7] == '0);
    end else begin : g_narrow
      assign valid = 1'b1;
    end
  endgenerate

  assign is_mem  = valid && (ir[6:5] == CLS_MEM);
  assign is_halt = valid && (ir[6:5] == CLS_SYS) && (ir[4:0] == 5'b11111);

  always_comb begin
    ctrl = '0;
    jump = 1'b0;
    if (valid && (state == EXEC || state == MEM_WAIT)) begin
      case (ir[6:5])
        CLS_ALU: begin
          if (state == EXEC) begin
            ctrl.salu    = ir[4:2];
            ctrl.lstatus = 1'b1;
            case (ir[1:0])
              2'b00: ctrl.lrega = 1'b1;
              2'b01: ctrl.lregb = 1'b1;
              2'b10: begin
                ctrl.lrega = 1'b1;
                ctrl.smuxb = MUXB_LIT;
              end
              default: ;
            endcase
          end
        end
        CLS_MEM: begin
          // address select and write strobe are held for the whole access
          ctrl.smuxd = ir[2];
          if (ir[4]) begin
            ctrl.wdm   = 1'b1;
            ctrl.smuxa = MUXA_A;
            ctrl.smuxb = MUXB_ZERO;
            ctrl.salu  = ALU_PASS;
          end else if (state == MEM_WAIT && mem_ready) begin
            ctrl.smuxa = MUXA_ZERO;
            ctrl.smuxb = MUXB_DM;
            ctrl.salu  = ALU_PASS;
            ctrl.lrega = !ir[3];
            ctrl.lregb = ir[3];
          end
        end
        CLS_JMP: begin
          if (state == EXEC) begin
            jump = cond_met(ir[4:2], flags);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control unit: FSM, PC, instruction register, timeout
import cu_pkg::*;

module control_sequencer #(
  parameter int PCW     = 7,
  parameter int OPW     = 7,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] instr,
  input  logic [PCW-1:0] lit,
  input  logic [3:0]     dataRegS,
  input  logic           memReady,
  output logic [PCW-1:0] pc,
  output logic           lRegA,
  output logic           lRegB,
  output logic [1:0]     sMuxA,
  output logic [1:0]     sMuxB,
  output logic [2:0]     sAlu,
  output logic           wDM,
  output logic           sMuxD,
  output logic           lPC,
  output logic           lStatus,
  output logic           halted,
  output logic           memErr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t         state, state_n;
  logic [OPW-1:0] ir;
  logic [PCW-1:0] lit_q;
  logic [PCW-1:0] pc_n;
  logic [CW-1:0]  cnt;
  ctrl_t          ctrl;
  logic           jump, is_mem, is_halt;
  logic           set_halt, set_err;

  cu_decode #(.OPW(OPW)) u_decode (
    .state     (state),
    .ir        (ir),
    .flags     (dataRegS),
    .mem_ready (memReady),
    .ctrl      (ctrl),
    .jump      (jump),
    .is_mem    (is_mem),
    .is_halt   (is_halt)
  );

  assign lRegA   = ctrl.lrega;
  assign lRegB   = ctrl.lregb;
  assign sMuxA   = ctrl.smuxa;
  assign sMuxB   = ctrl.smuxb;
  assign sAlu    = ctrl.salu;
  assign wDM     = ctrl.wdm;
  assign sMuxD   = ctrl.smuxd;
  assign lStatus = ctrl.lstatus;
  assign lPC     = jump;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    set_halt = 1'b0;
    set_err  = 1'b0;
    case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        if (is_mem) begin
          state_n = MEM_WAIT;
        end else begin
          pc_n = jump ? lit_q : pc + PCW'(1);
          if (is_halt) begin
            state_n  = HALT;
            set_halt = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          pc_n    = pc + PCW'(1);
          state_n = FETCH;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n  = HALT;
          set_halt = 1'b1;
          set_err  = 1'b1;
        end
      end
      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      lit_q  <= '0;
      cnt    <= '0;
      halted <= 1'b0;
      memErr <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == FETCH) begin
        ir    <= instr;
        lit_q <= lit;
      end
      // cleared while in EXEC so every MEM_WAIT entry starts from zero
      if (state == MEM_WAIT) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
      if (set_halt) halted <= 1'b1;
      if (set_err)  memErr <= 1'b1;
    end
  end

endmodule
